uart_cmd_decoder: RTL

downstream of the UART byte receiver. Consumes the received byte stream, parses "&&<C><digits>&&" command frames and emits one decoded command per frame.

Interface
REQ-001 Parameter MAX_GAP_CLK, default 49_999: inter-byte timeout in clocks (1 ms at 50 MHz).
REQ-002 Parameter MAX_DIGITS, default 9: maximum number of decimal digits accepted.
REQ-003 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  received byte; valid only while rx_vld=1.
REQ-006 rx_vld  in  1  one-cycle strobe per received byte.
REQ-007 cmd_code  out  8  ASCII command letter of the last good frame.
REQ-008 cmd_value  out  32  unsigned decimal value of the last good frame.
REQ-009 cmd_vld  out  1  one-cycle pulse when cmd_code/cmd_value update.
REQ-010 err  out  1  one-cycle pulse on a frame error.
REQ-011 err_code  out  3  cause of the last err pulse; held until the next err.
REQ-012 busy  out  1  high whenever state != IDLE.

Function
REQ-013 States: IDLE, SOF2, CMD, VALUE, EOF2; transitions occur only on rx_vld, except for timeout.
REQ-014 IDLE: '&' -> SOF2; any other byte is ignored silently.
REQ-015 SOF2: '&' -> CMD; other byte -> IDLE with err, err_code=1 (bad start).
REQ-016 CMD: 'A'..'Z' -> latch the letter into the internal code register, clear accumulator and digit count, -> VALUE.
REQ-017 CMD: an extra '&' keeps the FSM in CMD; any other byte -> IDLE with err_code=2 (bad command).
REQ-018 VALUE: '0'..'9' -> acc <= acc*10 + (byte-8'h30), digit count +1.
REQ-019 VALUE: a digit arriving when digit count = MAX_DIGITS -> IDLE with err_code=4 (overflow); the accumulator is never wider than 32 bits.
REQ-020 VALUE: '&' with digit count >= 1 -> EOF2.
REQ-021 VALUE: '&' with zero digits, or any other byte -> IDLE with err_code=3 (format).
REQ-022 EOF2: '&' -> IDLE; cmd_code <= latched letter, cmd_value <= acc, cmd_vld pulses in the cycle after that byte's rx_vld (latency 1).
REQ-023 EOF2: any other byte -> IDLE with err_code=3.
REQ-024 Gap counter: cleared on every rx_vld and in IDLE; otherwise increments.
REQ-025 Timeout: gap counter = MAX_GAP_CLK in a non-IDLE state -> IDLE with err_code=5 (timeout).
REQ-026 When rx_vld coincides with gap counter = MAX_GAP_CLK, the byte wins: it is processed and no timeout is raised.
REQ-027 err and cmd_vld are mutually exclusive; each is exactly one cycle wide.
REQ-028 After any error the FSM is in IDLE and resynchronises on the next "&&".
REQ-029 cmd_code/cmd_value are unchanged by errors and by incomplete frames.
REQ-030 rx_vld on consecutive cycles is fully supported; there is no back-pressure.

Reset
REQ-031 sys_rst=1 -> state IDLE; cmd_code=0, cmd_value=0, cmd_vld=0, err=0, err_code=0, busy=0; accumulator, digit count and gap counter cleared.
REQ-032 Reset asserted mid-frame discards the partial frame without an err pulse.
REQ-033 The first byte is accepted on the first cycle with sys_rst=0.

Verification
REQ-034 "&&F1234&&" -> one cmd_vld; cmd_code=8'h46, cmd_value=1234; err never asserts; busy low afterwards.
REQ-035 "&&A999999999&&" -> cmd_value=999999999; "&&A1234567890&&" -> err_code=4 at the 10th digit, cmd_value unchanged.
REQ-036 "&&B&&" -> err_code=3; "&&7..." -> err_code=2; "&x" -> err_code=1; "xyz" alone -> no pulse at all.
REQ-037 "&&C12" then silence -> err_code=5 exactly MAX_GAP_CLK clocks after the '2'; a byte presented on the expiry cycle -> no error.
REQ-038 "&&&D5&&" and "&&Z5&q&&E7&&" -> cmd D/5; then err_code=3 followed by cmd E/7.
REQ-039 sys_rst pulsed after "&&G4" -> all outputs 0; a following "&&H9&&" yields H/9.

---
 rtl/uart_cmd_decoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
// Parses "&&<C><digits>&&" frames from a UART byte stream and emits one
// decoded command (letter + unsigned decimal value) per good frame.
module uart_cmd_decoder #(
    parameter int unsigned MAX_GAP_CLK = 49_999,
    parameter int unsigned MAX_DIGITS  = 9
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic [7:0]  cmd_code,
    output logic [31:0] cmd_value,
    output logic        cmd_vld,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        busy
);

    localparam int unsigned GAP_BITS = $clog2(MAX_GAP_CLK + 1);
    localparam int unsigned GAP_W    = (GAP_BITS < 1) ? 1 : GAP_BITS;
    localparam int unsigned DIG_BITS = $clog2(MAX_DIGITS + 1);
    localparam int unsigned DIG_W    = (DIG_BITS < 1) ? 1 : DIG_BITS;

    localparam logic [7:0] CH_AMP = 8'h26;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF2,
        S_CMD,
        S_VALUE,
        S_EOF2
    } state_t;

    typedef enum logic [2:0] {
        E_NONE  = 3'd0,
        E_START = 3'd1,
        E_CMD   = 3'd2,
        E_FMT   = 3'd3,
        E_OVF   = 3'd4,
        E_TMO   = 3'd5
    } err_t;

    state_t             state_q, state_d;
    logic [7:0]         code_q, code_d;
    logic [31:0]        acc_q, acc_d;
    logic [DIG_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         cmd_code_q, cmd_code_d;
    logic [31:0]        cmd_value_q, cmd_value_d;
    logic               cmd_vld_q, cmd_vld_d;
    logic               err_q, err_d;
    err_t               err_code_q, err_code_d;

    logic               is_amp;
    logic               is_digit;
    logic               is_upper;
    logic               fail;
    err_t               fail_code;

    assign is_amp   = (rx_data == CH_AMP);
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_upper = (rx_data >= 8'h41) && (rx_data <= 8'h5A);

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cmd_code_d  = cmd_code_q;
        cmd_value_d = cmd_value_q;
        cmd_vld_d   = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        fail        = 1'b0;
        fail_code   = E_NONE;
        gap_d       = (state_q == S_IDLE || rx_vld) ? '0 : gap_q + GAP_W'(1);

        // A byte on the expiry cycle takes priority over the timeout.
        if (rx_vld) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_amp) state_d = S_SOF2;
                end
                S_SOF2: begin
                    if (is_amp) begin
                        state_d = S_CMD;
                    end else begin
                        fail      = 1'b1;
                        fail_code = E_START;
                    end
                end
                S_CMD: begin
                    if (is_upper) begin
                        code_d  = rx_data;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_VALUE;
                    end else if (!is_amp) begin
                        fail      = 1'b1;
                        fail_code = E_CMD;
                    end
                end
                S_VALUE: begin
                    if (is_digit) begin
                        if (cnt_q == DIG_W'(MAX_DIGITS)) begin
                            fail      = 1'b1;
                            fail_code = E_OVF;
                        end else begin
                            acc_d = acc_q * 32'd10 + {24'h0, rx_data - 8'h30};
                            cnt_d = cnt_q + DIG_W'(1);
                        end
                    end else if (is_amp && cnt_q != '0) begin
                        state_d = S_EOF2;
                    end else begin
                        fail      = 1'b1;
                        fail_code = E_FMT;
                    end
                end
                S_EOF2: begin
                    if (is_amp) begin
                        state_d     = S_IDLE;
                        cmd_code_d  = code_q;
                        cmd_value_d = acc_q;
                        cmd_vld_d   = 1'b1;
                    end else begin
                        fail      = 1'b1;
                        fail_code = E_FMT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && gap_q == GAP_W'(MAX_GAP_CLK)) begin
            fail      = 1'b1;
            fail_code = E_TMO;
        end

        if (fail) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = fail_code;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            cmd_code_q  <= '0;
            cmd_value_q <= '0;
            cmd_vld_q   <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= E_NONE;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            cmd_code_q  <= cmd_code_d;
            cmd_value_q <= cmd_value_d;
            cmd_vld_q   <= cmd_vld_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign cmd_code  = cmd_code_q;
    assign cmd_value = cmd_value_q;
    assign cmd_vld   = cmd_vld_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != S_IDLE);

endmodule
